// File: rtl/booth_ctrl.sv
// booth_ctrl: Moore sequencer for a radix-2 Booth multiplier datapath.
// It steps the A/Q/Q-1 registers through load, Booth-pair evaluation, add/sub
// and arithmetic shift for N iterations, then pulses done for one cycle.
// Every output is a flop loaded from the decode of the next state, so the
// outputs carry no combinational path from any input.
module booth_ctrl #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          q0,
    input  logic          q_m1,
    output logic          ready,
    output logic          busy,
    output logic          load,
    output logic          add,
    output logic          sub,
    output logic          shift,
    output logic          done,
    output logic [CW-1:0] iter_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        EVAL  = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        SHIFT = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(N);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_d;
    logic          ready_d;
    logic          busy_d;
    logic          load_d;
    logic          add_d;
    logic          sub_d;
    logic          shift_d;
    logic          done_d;

    // Next state, next iteration count and next-state strobe decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = iter_cnt;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        load_d  = 1'b0;
        add_d   = 1'b0;
        sub_d   = 1'b0;
        shift_d = 1'b0;
        done_d  = 1'b0;

        if (abort && (state_q != IDLE)) begin
            // Cancel drops straight back to idle; the datapath is abandoned.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    cnt_d   = '0;
                    state_d = EVAL;
                end
                EVAL: begin
                    unique case ({q0, q_m1})
                        2'b10:   state_d = SUB;
                        2'b01:   state_d = ADD;
                        default: state_d = SHIFT;
                    endcase
                end
                ADD: begin
                    state_d = SHIFT;
                end
                SUB: begin
                    state_d = SHIFT;
                end
                SHIFT: begin
                    cnt_d = iter_cnt + CNT_ONE;
                    if (cnt_d == CNT_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = EVAL;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        load_d  = (state_d == LOAD);
        add_d   = (state_d == ADD);
        sub_d   = (state_d == SUB);
        shift_d = (state_d == SHIFT);
        done_d  = (state_d == DONE);
    end

    // State, counter and registered strobes; reset forces idle immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            iter_cnt <= '0;
            ready    <= 1'b1;
            busy     <= 1'b0;
            load     <= 1'b0;
            add      <= 1'b0;
            sub      <= 1'b0;
            shift    <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            iter_cnt <= cnt_d;
            ready    <= ready_d;
            busy     <= busy_d;
            load     <= load_d;
            add      <= add_d;
            sub      <= sub_d;
            shift    <= shift_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_booth_ctrl.sv
// tb_booth_ctrl: directed and random sequences for booth_ctrl at N=4 and N=8.
// A small Q/Q-1 register model answers the strobes; the expected per-cycle
// strobe trace is derived straight from the multiplier bits.
module tb_booth_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       q0;
    logic       q_m1;

    logic       r4, b4, l4, a4, s4, h4, d4;
    logic [2:0] c4;
    logic       r8, b8, l8, a8, s8, h8, d8;
    logic [3:0] c8;

    int         sel;
    int         nvec;
    int         nerr;
    int         exp_cnt;
    logic [7:0] mult_cur;
    logic [7:0] dq;
    logic       dqm1;

    typedef enum int {K_IDLE, K_LOAD, K_EVAL, K_ADD, K_SUB, K_SHIFT, K_DONE} kind_t;
    typedef struct {
        kind_t k;
        int    c;
    } step_t;

    always #5 clk = ~clk;

    booth_ctrl #(.N(4)) u4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .q0(q0), .q_m1(q_m1),
        .ready(r4), .busy(b4), .load(l4), .add(a4), .sub(s4), .shift(h4),
        .done(d4), .iter_cnt(c4)
    );

    booth_ctrl #(.N(8)) u8 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .q0(q0), .q_m1(q_m1),
        .ready(r8), .busy(b8), .load(l8), .add(a8), .sub(s8), .shift(h8),
        .done(d8), .iter_cnt(c8)
    );

    // {ready, busy, load, add, sub, shift, done, iter_cnt[3:0]} of the selected DUT
    function automatic logic [10:0] obs();
        if (sel == 0) return {r4, b4, l4, a4, s4, h4, d4, 1'b0, c4};
        return {r8, b8, l8, a8, s8, h8, d8, c8};
    endfunction

    function automatic logic [10:0] expw(input kind_t k, input int c);
        logic [6:0] f;
        f = {k == K_IDLE, k != K_IDLE, k == K_LOAD, k == K_ADD,
             k == K_SUB, k == K_SHIFT, k == K_DONE};
        return {f, 4'(c)};
    endfunction

    task automatic chk(input string tag, input logic [10:0] e);
        logic [10:0] o;
        o = obs();
        nvec++;
        assert (o === e) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Datapath stand-in: load captures the multiplier, shift moves Q into Q-1.
    task automatic dp_update();
        logic [10:0] o;
        o = obs();
        if (o[8]) begin
            dq   = mult_cur;
            dqm1 = 1'b0;
        end
        if (o[5]) begin
            dqm1 = dq[0];
            dq   = dq >> 1;
        end
        q0   = dq[0];
        q_m1 = dqm1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        chk(tag, expw(K_IDLE, 0));
        step();
        chk(tag, expw(K_IDLE, 0));
        rst     = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic run(input logic [7:0] m, input int n, input bit keep,
                       input int abort_eval, input bit rst_sub, input string tag);
        step_t q[$];
        int    c;
        int    evals;
        bit    prev;
        bit    b;
        mult_cur = m;
        q.push_back(step_t'{K_LOAD, exp_cnt});
        c    = 0;
        prev = 1'b0;
        for (int i = 0; i < n; i++) begin
            b = m[i];
            q.push_back(step_t'{K_EVAL, c});
            if (b && !prev) q.push_back(step_t'{K_SUB, c});
            else if (!b && prev) q.push_back(step_t'{K_ADD, c});
            q.push_back(step_t'{K_SHIFT, c});
            c++;
            prev = b;
        end
        q.push_back(step_t'{K_DONE, n});

        start = 1'b1;
        evals = 0;
        for (int i = 0; i < q.size(); i++) begin
            step();
            chk(tag, expw(q[i].k, q[i].c));
            dp_update();
            if (i == 0 && !keep) start = 1'b0;
            if (q[i].k == K_EVAL) evals++;
            if (abort_eval != 0 && q[i].k == K_EVAL && evals == abort_eval) begin
                abort = 1'b1;
                step();
                chk({tag, "_abort"}, expw(K_IDLE, 0));
                abort   = 1'b0;
                exp_cnt = 0;
                repeat (3) begin
                    step();
                    chk({tag, "_post_abort"}, expw(K_IDLE, 0));
                end
                return;
            end
            if (rst_sub && q[i].k == K_SUB) begin
                rst = 1'b0;
                #1;
                chk({tag, "_rst_async"}, expw(K_IDLE, 0));
                step();
                chk({tag, "_rst_held"}, expw(K_IDLE, 0));
                rst     = 1'b1;
                exp_cnt = 0;
                repeat (3) begin
                    step();
                    chk({tag, "_post_rst"}, expw(K_IDLE, 0));
                end
                return;
            end
        end
        step();
        chk({tag, "_idle"}, expw(K_IDLE, n));
        exp_cnt = n;
    endtask

    initial begin
        nvec     = 0;
        nerr     = 0;
        exp_cnt  = 0;
        sel      = 0;
        rst      = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        q0       = 1'b0;
        q_m1     = 1'b0;
        dq       = '0;
        dqm1     = 1'b0;
        mult_cur = '0;

        repeat (2) @(posedge clk);
        #1;
        sel = 0;
        chk("reset4", expw(K_IDLE, 0));
        sel = 1;
        chk("reset8", expw(K_IDLE, 0));
        sel = 0;
        rst = 1'b1;
        step();
        chk("idle_after_reset", expw(K_IDLE, 0));

        // N=4 directed and random multipliers
        run(8'h06, 4, 1'b0, 0, 1'b0, "mul4_0110");
        repeat (4) run(8'($urandom & 32'hF), 4, 1'b0, 0, 1'b0, "mul4_rand");

        // N=8
        sel = 1;
        do_reset("reset_switch");
        run(8'h00, 8, 1'b0, 0, 1'b0, "mul8_00");
        run(8'h55, 8, 1'b0, 0, 1'b0, "mul8_55");
        run(8'hFF, 8, 1'b0, 0, 1'b0, "mul8_ff");
        repeat (4) run(8'($urandom), 8, 1'b0, 0, 1'b0, "mul8_rand");

        // start held high: busy starts ignored, load two cycles after done
        repeat (3) run(8'($urandom), 8, 1'b1, 0, 1'b0, "b2b");
        start = 1'b0;
        step();
        chk("b2b_end", expw(K_IDLE, 8));

        // abort on the third EVAL
        run(8'($urandom), 8, 1'b0, 3, 1'b0, "abort_eval3");

        // start and abort together in idle: abort wins
        start = 1'b1;
        abort = 1'b1;
        repeat (4) begin
            step();
            chk("start_abort_idle", expw(K_IDLE, 0));
        end
        start = 1'b0;
        abort = 1'b0;

        // reset in the middle of a SUB, then a clean operation
        run(8'h02, 8, 1'b0, 0, 1'b1, "rst_mid_sub");
        run(8'($urandom), 8, 1'b0, 0, 1'b0, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
